// File: rtl/wt_l15_req_sched.sv
// Round-robin scheduler merging I$ and D$ requests onto a single L1.5 request port,
// with per-requester outstanding-transaction credit tracking.
module wt_l15_req_sched #(
    parameter int unsigned PLEN   = 56,
    parameter int unsigned TID_W  = 2,
    parameter int unsigned MAX_TX = 4,
    localparam int unsigned CW    = $clog2(MAX_TX + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ic_req_valid_i,
    output logic              ic_req_ready_o,
    input  logic [PLEN-1:0]   ic_paddr_i,
    input  logic              ic_nc_i,
    input  logic [TID_W-1:0]  ic_tid_i,
    input  logic              dc_req_valid_i,
    output logic              dc_req_ready_o,
    input  logic [1:0]        dc_rtype_i,
    input  logic [2:0]        dc_size_i,
    input  logic [PLEN-1:0]   dc_paddr_i,
    input  logic [63:0]       dc_data_i,
    input  logic              dc_nc_i,
    input  logic [TID_W-1:0]  dc_tid_i,
    input  logic [3:0]        dc_amo_i,
    output logic              l15_val_o,
    input  logic              l15_ack_i,
    output logic [4:0]        l15_rqtype_o,
    output logic [2:0]        l15_size_o,
    output logic [39:0]       l15_address_o,
    output logic [63:0]       l15_data_o,
    output logic              l15_nc_o,
    output logic [TID_W-1:0]  l15_threadid_o,
    output logic [3:0]        l15_amo_op_o,
    input  logic              ic_done_i,
    input  logic              dc_done_i,
    output logic [CW-1:0]     ic_credit_o,
    output logic [CW-1:0]     dc_credit_o,
    output logic              err_o
);

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    localparam logic [1:0] RT_STORE  = 2'd0;
    localparam logic [1:0] RT_LOAD   = 2'd1;
    localparam logic [1:0] RT_ATOMIC = 2'd2;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_dc;
    logic [CW-1:0]     r_ic_cnt;
    logic [CW-1:0]     r_dc_cnt;
    logic              r_err;
    logic              r_val;
    logic [4:0]        r_rqtype;
    logic [2:0]        r_size;
    logic [39:0]       r_address;
    logic [63:0]       r_data;
    logic              r_nc;
    logic [TID_W-1:0]  r_tid;
    logic [3:0]        r_amo;

    logic              w_ic_elig;
    logic              w_dc_elig;
    logic              w_ic_gnt;
    logic              w_dc_gnt;
    logic [4:0]        w_dc_rqtype;
    logic [2:0]        w_dc_size;
    logic [63:0]       w_dc_data;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_word;
    logic              w_unused;

    assign w_unused = ^{ic_paddr_i[PLEN-1:40], dc_paddr_i[PLEN-1:40]};

    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt,
                                               input logic gnt, input logic done);
        if (gnt && !done)
            return cnt + CW'(1);
        if (!gnt && done && (cnt != '0))
            return cnt - CW'(1);
        return cnt;
    endfunction

    // Next state and grant; a tie goes to whoever was not granted last
    always_comb begin
        w_state_nxt = r_state;
        w_ic_gnt    = 1'b0;
        w_dc_gnt    = 1'b0;
        w_ic_elig   = ic_req_valid_i && (r_ic_cnt < CW'(MAX_TX));
        w_dc_elig   = dc_req_valid_i && (r_dc_cnt < CW'(MAX_TX));
        case (r_state)
            ST_IDLE: begin
                if (!rst_i) begin
                    if (w_ic_elig && w_dc_elig) begin
                        w_dc_gnt = ~r_last_dc;
                        w_ic_gnt = r_last_dc;
                    end else begin
                        w_ic_gnt = w_ic_elig;
                        w_dc_gnt = w_dc_elig;
                    end
                end
                if (w_ic_gnt || w_dc_gnt)
                    w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (l15_ack_i)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    assign ic_req_ready_o = w_ic_gnt;
    assign dc_req_ready_o = w_dc_gnt;

    // D$ payload: sub-doubleword stores/atomics replicate the addressed lane
    assign w_byte = dc_data_i[{dc_paddr_i[2:0], 3'b000} +: 8];
    assign w_half = dc_data_i[{dc_paddr_i[2:1], 4'b0000} +: 16];
    assign w_word = dc_data_i[{dc_paddr_i[2], 5'b00000} +: 32];

    always_comb begin
        w_dc_rqtype = 5'b00000;
        w_dc_size   = dc_size_i;
        w_dc_data   = dc_data_i;
        case (dc_rtype_i)
            RT_STORE:  w_dc_rqtype = 5'b00001;
            RT_LOAD:   w_dc_rqtype = 5'b00000;
            RT_ATOMIC: w_dc_rqtype = 5'b00110;
            default:   w_dc_rqtype = 5'b01001;
        endcase
        if ((dc_rtype_i == RT_LOAD) && !dc_nc_i)
            w_dc_size = 3'b111;
        if ((dc_rtype_i == RT_STORE) || (dc_rtype_i == RT_ATOMIC)) begin
            case (dc_size_i)
                3'd0:    w_dc_data = {8{w_byte}};
                3'd1:    w_dc_data = {4{w_half}};
                3'd2:    w_dc_data = {2{w_word}};
                default: w_dc_data = dc_data_i;
            endcase
        end
    end

    // L1.5 request registers, captured on grant and held until ack
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_val     <= 1'b0;
            r_rqtype  <= '0;
            r_size    <= '0;
            r_address <= '0;
            r_data    <= '0;
            r_nc      <= 1'b0;
            r_tid     <= '0;
            r_amo     <= '0;
        end else if (w_ic_gnt) begin
            r_val     <= 1'b1;
            r_rqtype  <= 5'b10000;
            r_size    <= ic_nc_i ? 3'b010 : 3'b111;
            r_address <= ic_paddr_i[39:0];
            r_data    <= '0;
            r_nc      <= ic_nc_i;
            r_tid     <= ic_tid_i;
            r_amo     <= '0;
        end else if (w_dc_gnt) begin
            r_val     <= 1'b1;
            r_rqtype  <= w_dc_rqtype;
            r_size    <= w_dc_size;
            r_address <= dc_paddr_i[39:0];
            r_data    <= w_dc_data;
            r_nc      <= dc_nc_i;
            r_tid     <= dc_tid_i;
            r_amo     <= dc_amo_i;
        end else if ((r_state == ST_HOLD) && l15_ack_i) begin
            r_val     <= 1'b0;
        end
    end

    // Credits, round-robin history and sticky underflow flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ic_cnt  <= '0;
            r_dc_cnt  <= '0;
            r_err     <= 1'b0;
            r_last_dc <= 1'b0;
        end else begin
            r_ic_cnt <= cnt_next(r_ic_cnt, w_ic_gnt, ic_done_i);
            r_dc_cnt <= cnt_next(r_dc_cnt, w_dc_gnt, dc_done_i);
            if ((ic_done_i && (r_ic_cnt == '0)) || (dc_done_i && (r_dc_cnt == '0)))
                r_err <= 1'b1;
            if (w_ic_gnt)
                r_last_dc <= 1'b0;
            else if (w_dc_gnt)
                r_last_dc <= 1'b1;
        end
    end

    assign l15_val_o      = r_val;
    assign l15_rqtype_o   = r_rqtype;
    assign l15_size_o     = r_size;
    assign l15_address_o  = r_address;
    assign l15_data_o     = r_data;
    assign l15_nc_o       = r_nc;
    assign l15_threadid_o = r_tid;
    assign l15_amo_op_o   = r_amo;
    assign ic_credit_o    = r_ic_cnt;
    assign dc_credit_o    = r_dc_cnt;
    assign err_o          = r_err;

endmodule

// File: tb/tb_wt_l15_req_sched.sv
// Bench for wt_l15_req_sched: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wt_l15_req_sched;

    localparam int unsigned PLEN   = 56;
    localparam int unsigned TID_W  = 2;
    localparam int unsigned MAX_TX = 4;
    localparam int unsigned CW     = $clog2(MAX_TX + 1);

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              ic_req_valid_i, ic_req_ready_o, ic_nc_i;
    logic [PLEN-1:0]   ic_paddr_i;
    logic [TID_W-1:0]  ic_tid_i;
    logic              dc_req_valid_i, dc_req_ready_o, dc_nc_i;
    logic [1:0]        dc_rtype_i;
    logic [2:0]        dc_size_i;
    logic [PLEN-1:0]   dc_paddr_i;
    logic [63:0]       dc_data_i;
    logic [TID_W-1:0]  dc_tid_i;
    logic [3:0]        dc_amo_i;
    logic              l15_val_o, l15_ack_i, l15_nc_o;
    logic [4:0]        l15_rqtype_o;
    logic [2:0]        l15_size_o;
    logic [39:0]       l15_address_o;
    logic [63:0]       l15_data_o;
    logic [TID_W-1:0]  l15_threadid_o;
    logic [3:0]        l15_amo_op_o;
    logic              ic_done_i, dc_done_i, err_o;
    logic [CW-1:0]     ic_credit_o, dc_credit_o;

    wt_l15_req_sched #(.PLEN(PLEN), .TID_W(TID_W), .MAX_TX(MAX_TX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o),
        .ic_paddr_i(ic_paddr_i), .ic_nc_i(ic_nc_i), .ic_tid_i(ic_tid_i),
        .dc_req_valid_i(dc_req_valid_i), .dc_req_ready_o(dc_req_ready_o),
        .dc_rtype_i(dc_rtype_i), .dc_size_i(dc_size_i), .dc_paddr_i(dc_paddr_i),
        .dc_data_i(dc_data_i), .dc_nc_i(dc_nc_i), .dc_tid_i(dc_tid_i), .dc_amo_i(dc_amo_i),
        .l15_val_o(l15_val_o), .l15_ack_i(l15_ack_i), .l15_rqtype_o(l15_rqtype_o),
        .l15_size_o(l15_size_o), .l15_address_o(l15_address_o), .l15_data_o(l15_data_o),
        .l15_nc_o(l15_nc_o), .l15_threadid_o(l15_threadid_o), .l15_amo_op_o(l15_amo_op_o),
        .ic_done_i(ic_done_i), .dc_done_i(dc_done_i),
        .ic_credit_o(ic_credit_o), .dc_credit_o(dc_credit_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]       rq;
        logic [2:0]       size;
        logic [39:0]      addr;
        logic [63:0]      data;
        logic             nc;
        logic [TID_W-1:0] tid;
        logic [3:0]       amo;
    } req_t;

    int   n_checks = 0;
    int   n_err    = 0;
    bit   m_ok     = 1'b0;
    bit   m_busy;
    req_t m_req;
    int   m_cnt[2];
    bit   m_err;
    int   m_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Who the scheduler must grant this cycle: -1 none, 0 I$, 1 D$
    function automatic int pick();
        bit ei, ed;
        if (rst_i || m_busy)
            return -1;
        ei = ic_req_valid_i && (m_cnt[0] < MAX_TX);
        ed = dc_req_valid_i && (m_cnt[1] < MAX_TX);
        if (ei && ed)
            return (m_last == 0) ? 1 : 0;
        if (ei) return 0;
        if (ed) return 1;
        return -1;
    endfunction

    function automatic logic [63:0] repl(input logic [63:0] d, input int size, input int off);
        int n, base;
        logic [63:0] chunk, res;
        n     = 1 << size;
        base  = (off / n) * n;
        chunk = (d >> (8 * base)) & ((64'd1 << (8 * n)) - 64'd1);
        res   = '0;
        for (int k = 0; k < 8 / n; k++)
            res = res | (chunk << (8 * n * k));
        return res;
    endfunction

    function automatic req_t expect_req(input int who);
        req_t r;
        if (who == 0) begin
            r.rq   = 5'b10000;
            r.size = ic_nc_i ? 3'b010 : 3'b111;
            r.addr = ic_paddr_i[39:0];
            r.data = '0;
            r.nc   = ic_nc_i;
            r.tid  = ic_tid_i;
            r.amo  = '0;
        end else begin
            case (int'(dc_rtype_i))
                0:       r.rq = 5'b00001;
                1:       r.rq = 5'b00000;
                2:       r.rq = 5'b00110;
                default: r.rq = 5'b01001;
            endcase
            r.size = (dc_rtype_i == 2'd1 && !dc_nc_i) ? 3'b111 : dc_size_i;
            if ((dc_rtype_i == 2'd0 || dc_rtype_i == 2'd2) && dc_size_i < 3'd3)
                r.data = repl(dc_data_i, int'(dc_size_i), int'(dc_paddr_i[2:0]));
            else
                r.data = dc_data_i;
            r.addr = dc_paddr_i[39:0];
            r.nc   = dc_nc_i;
            r.tid  = dc_tid_i;
            r.amo  = dc_amo_i;
        end
        return r;
    endfunction

    task automatic compare();
        int g;
        if (!m_ok) return;
        g = pick();
        chk("ic_ready", 64'(ic_req_ready_o), 64'(g == 0));
        chk("dc_ready", 64'(dc_req_ready_o), 64'(g == 1));
        chk("l15_val", 64'(l15_val_o), 64'(m_busy));
        chk("ic_credit", 64'(ic_credit_o), 64'(m_cnt[0]));
        chk("dc_credit", 64'(dc_credit_o), 64'(m_cnt[1]));
        chk("err", 64'(err_o), 64'(m_err));
        if (m_busy) begin
            chk("rqtype", 64'(l15_rqtype_o), 64'(m_req.rq));
            chk("size", 64'(l15_size_o), 64'(m_req.size));
            chk("address", 64'(l15_address_o), 64'(m_req.addr));
            chk("data", l15_data_o, m_req.data);
            chk("nc", 64'(l15_nc_o), 64'(m_req.nc));
            chk("tid", 64'(l15_threadid_o), 64'(m_req.tid));
            chk("amo", 64'(l15_amo_op_o), 64'(m_req.amo));
        end
    endtask

    task automatic update();
        int  g;
        bit  dn[2];
        if (rst_i) begin
            m_ok = 1'b1; m_busy = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0;
            m_err = 1'b0; m_last = 0;
            return;
        end
        g = pick();
        dn[0] = ic_done_i;
        dn[1] = dc_done_i;
        for (int r = 0; r < 2; r++) begin
            if (dn[r] && m_cnt[r] == 0) m_err = 1'b1;
            if (g == r && !dn[r]) m_cnt[r]++;
            else if (g != r && dn[r] && m_cnt[r] > 0) m_cnt[r]--;
        end
        if (m_busy) begin
            if (l15_ack_i) m_busy = 1'b0;
        end else if (g >= 0) begin
            m_busy = 1'b1;
            m_req  = expect_req(g);
            m_last = g;
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        compare();
        @(posedge clk_i);
        update();
        #1;
    endtask

    task automatic clr_in();
        rst_i = 1'b0; ic_req_valid_i = 1'b0; ic_nc_i = 1'b0; ic_paddr_i = '0; ic_tid_i = '0;
        dc_req_valid_i = 1'b0; dc_rtype_i = '0; dc_size_i = '0; dc_paddr_i = '0;
        dc_data_i = '0; dc_nc_i = 1'b0; dc_tid_i = '0; dc_amo_i = '0;
        l15_ack_i = 1'b0; ic_done_i = 1'b0; dc_done_i = 1'b0;
    endtask

    task automatic do_reset();
        clr_in();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        clr_in();
        #1;
        do_reset();
        do_reset();
        chk("rst_val", 64'(l15_val_o), 64'd0);
        chk("rst_rqtype", 64'(l15_rqtype_o), 64'd0);
        chk("rst_data", l15_data_o, 64'd0);
        chk("rst_address", 64'(l15_address_o), 64'd0);
        chk("rst_credits", 64'({ic_credit_o, dc_credit_o}), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);

        // I$ fill right after reset
        ic_req_valid_i = 1'b1; ic_paddr_i = PLEN'(64'h8000_1000);
        #1 chk("d21_ready", 64'(ic_req_ready_o), 64'd1);
        step();
        ic_req_valid_i = 1'b0;
        chk("d21_val", 64'(l15_val_o), 64'd1);
        chk("d21_rqtype", 64'(l15_rqtype_o), 64'h10);
        chk("d21_size", 64'(l15_size_o), 64'h7);
        chk("d21_addr", 64'(l15_address_o), 64'h8000_1000);

        // Tie alternation D, I, D, I with immediate ack
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ic_req_valid_i = 1'b1; dc_req_valid_i = 1'b1; l15_ack_i = 1'b0;
            #1 chk("d22_dc_grant", 64'(dc_req_ready_o), 64'((i % 2) == 0));
            chk("d22_ic_grant", 64'(ic_req_ready_o), 64'((i % 2) == 1));
            step();
            ic_req_valid_i = 1'b0; dc_req_valid_i = 1'b0; l15_ack_i = 1'b1;
            step();
        end
        l15_ack_i = 1'b0;

        // Byte store replication, held until ack
        do_reset();
        dc_req_valid_i = 1'b1; dc_rtype_i = 2'd0; dc_size_i = 3'd0;
        dc_paddr_i = PLEN'(64'h1005); dc_data_i = 64'h0000_AB00_0000_0000;
        step();
        dc_req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("d23_val", 64'(l15_val_o), 64'd1);
            chk("d23_data", l15_data_o, 64'hABAB_ABAB_ABAB_ABAB);
            l15_ack_i = (i == 2);
            step();
        end
        l15_ack_i = 1'b0;
        chk("d23_val_drop", 64'(l15_val_o), 64'd0);

        // D$ credit exhaustion, I$ unaffected, reopen after a done
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dc_req_valid_i = 1'b1; dc_rtype_i = 2'd1; l15_ack_i = 1'b0;
            step();
            dc_req_valid_i = 1'b0; l15_ack_i = 1'b1;
            step();
        end
        l15_ack_i = 1'b0;
        chk("d24_credit4", 64'(dc_credit_o), 64'd4);
        ic_req_valid_i = 1'b1; dc_req_valid_i = 1'b1;
        #1 chk("d24_dc_blocked", 64'(dc_req_ready_o), 64'd0);
        chk("d24_ic_granted", 64'(ic_req_ready_o), 64'd1);
        step();
        ic_req_valid_i = 1'b0; l15_ack_i = 1'b1;
        step();
        l15_ack_i = 1'b0; dc_done_i = 1'b1;
        #1 chk("d24_dc_still_blocked", 64'(dc_req_ready_o), 64'd0);
        step();
        dc_done_i = 1'b0;
        #1 chk("d24_dc_reopened", 64'(dc_req_ready_o), 64'd1);
        step();
        dc_req_valid_i = 1'b0;
        chk("d24_credit_back", 64'(dc_credit_o), 64'd4);

        // Underflow: count stays 0, error sticky until reset
        do_reset();
        dc_done_i = 1'b1;
        step();
        dc_done_i = 1'b0;
        chk("d25_credit", 64'(dc_credit_o), 64'd0);
        chk("d25_err", 64'(err_o), 64'd1);
        repeat (3) step();
        chk("d25_err_sticky", 64'(err_o), 64'd1);
        do_reset();
        chk("d25_err_cleared", 64'(err_o), 64'd0);

        // Reset during HOLD
        ic_req_valid_i = 1'b1;
        step();
        ic_req_valid_i = 1'b0;
        step();
        chk("d26_hold", 64'(l15_val_o), 64'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("d26_val", 64'(l15_val_o), 64'd0);
        chk("d26_ic_credit", 64'(ic_credit_o), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_i          = ($urandom_range(0, 99) == 0);
            ic_req_valid_i = $urandom_range(0, 1) == 1;
            ic_nc_i        = $urandom_range(0, 1) == 1;
            ic_paddr_i     = PLEN'({$urandom(), $urandom()});
            ic_tid_i       = TID_W'($urandom());
            dc_req_valid_i = $urandom_range(0, 1) == 1;
            dc_rtype_i     = 2'($urandom());
            dc_size_i      = 3'($urandom());
            dc_paddr_i     = PLEN'({$urandom(), $urandom()});
            dc_data_i      = {$urandom(), $urandom()};
            dc_nc_i        = $urandom_range(0, 1) == 1;
            dc_tid_i       = TID_W'($urandom());
            dc_amo_i       = 4'($urandom());
            l15_ack_i      = $urandom_range(0, 9) < 4;
            ic_done_i      = (m_cnt[0] > 0) && ($urandom_range(0, 9) < 2);
            dc_done_i      = (m_cnt[1] > 0) && ($urandom_range(0, 9) < 2);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/wt_l15_req_sched.md
WT_L15_REQ_SCHED -- requirements
Module: wt_l15_req_sched

Interface
REQ-001 SHALL have parameter PLEN, default 56, physical address width (at least 40).
REQ-002 SHALL have parameter TID_W, default 2, transaction ID width.
REQ-003 SHALL have parameter MAX_TX, default 4, maximum outstanding transactions per requester; CW = clog2(MAX_TX+1).
REQ-004 SHALL have ports:
- clk_i  in  1  clock; one clock only, all logic on the rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- ic_req_valid_i  in  1  I$ fill request.
- ic_req_ready_o  out  1  I$ request captured.
- ic_paddr_i  in  PLEN  I$ address.
- ic_nc_i  in  1  I$ non-cacheable.
- ic_tid_i  in  TID_W  I$ transaction ID.
- dc_req_valid_i  in  1  D$ request.
- dc_req_ready_o  out  1  D$ request captured.
- dc_rtype_i  in  2  0 = store, 1 = load, 2 = atomic, 3 = interrupt.
- dc_size_i  in  3  D$ size code.
- dc_paddr_i  in  PLEN  D$ address.
- dc_data_i  in  64  D$ write data.
- dc_nc_i  in  1  D$ non-cacheable.
- dc_tid_i  in  TID_W  D$ transaction ID.
- dc_amo_i  in  4  atomic opcode.
- l15_val_o  out  1  request valid.
- l15_ack_i  in  1  L1.5 accepted the request.
- l15_rqtype_o  out  5  L1.5 request type.
- l15_size_o  out  3  request size.
- l15_address_o  out  40  paddr[39:0].
- l15_data_o  out  64  write data.
- l15_nc_o  out  1  non-cacheable.
- l15_threadid_o  out  TID_W  transaction ID.
- l15_amo_op_o  out  4  atomic opcode.
- ic_done_i  in  1  pulse: one I$ transaction has returned.
- dc_done_i  in  1  pulse: one D$ transaction has returned.
- ic_credit_o  out  CW  I$ outstanding count.
- dc_credit_o  out  CW  D$ outstanding count.
- err_o  out  1  sticky underflow error.

Function
REQ-005 SHALL implement a two-state FSM, IDLE and HOLD.
REQ-006 In IDLE, a requester is eligible when its valid input is 1 and its outstanding count is below MAX_TX.
REQ-007 Arbitration SHALL be round-robin:
- If only one requester is eligible, it is granted.
- If both are eligible, the requester not granted last time is granted.
- The last-grant register resets to I$, so D$ wins the first tie.
REQ-008 On a grant in IDLE, the scheduler SHALL:
- pulse the granted ready output for exactly that cycle;
- register all l15_* fields;
- go to HOLD.
l15_val_o SHALL be 1 from the next cycle on. Latency from valid to l15_val_o is 1 cycle.
REQ-009 In HOLD, l15_val_o SHALL be 1 and every l15_* field SHALL stay stable until the cycle in which l15_ack_i = 1; the FSM then returns to IDLE and l15_val_o is 0 in the following cycle.
REQ-010 Both ready outputs SHALL be 0 in HOLD. Sustained throughput is at most one request per two cycles.
REQ-011 l15_ack_i SHALL be ignored in IDLE.
REQ-012 An I$ grant SHALL encode:
- rqtype = 5'b10000;
- size = 3'b111 if ic_nc_i = 0, otherwise 3'b010;
- data = 0 and amo = 0.
REQ-013 A D$ grant SHALL encode rqtype by dc_rtype_i: 0 → 5'b00001, 1 → 5'b00000, 2 → 5'b00110, 3 → 5'b01001.
REQ-014 For a D$ load with dc_nc_i = 0, size SHALL be 3'b111; for every other D$ grant, size = dc_size_i.
REQ-015 For D$ stores and atomics with size 0, 1 or 2, data SHALL replicate the addressed byte, halfword or word (selected by paddr[2:0]) across all 64 bits; size 3 passes the data unchanged.
REQ-016 Each outstanding counter SHALL:
- increment on a grant to that requester;
- decrement on that requester's done pulse;
- stay unchanged when a grant and a done pulse occur in the same cycle.
REQ-017 A done pulse while the count is 0 SHALL leave the count at 0 and set err_o, which stays 1 until reset.
REQ-018 When a count reaches MAX_TX, that requester SHALL NOT be granted; the other requester is unaffected.

Reset
REQ-019 While rst_i = 1 at a clock edge, the FSM SHALL go to IDLE and all of these SHALL become 0: l15_* outputs, counters, err_o, ready outputs. The last-grant register becomes I$.
REQ-020 A reset asserted during HOLD SHALL drop l15_val_o after that edge with no ack required; the outstanding counts are discarded.

Verification
REQ-021 After reset, I$ request with paddr 0x80001000, nc = 0 → ic_req_ready_o pulses; next cycle l15_val_o = 1, rqtype 10000, size 111, address 0x80001000.
REQ-022 Both valid in the same IDLE cycle, repeatedly, with immediate ack → grants alternate D, I, D, I.
REQ-023 D$ store, size 0, paddr[2:0] = 5, data 0x0000AB0000000000 → l15_data_o = 0xABABABABABABABAB; output held for 3 cycles until ack.
REQ-024 Four D$ grants with no done pulses → dc_credit_o = 4 and dc_req_ready_o stays 0; I$ is still granted. One dc_done_i → D$ is granted again.
REQ-025 dc_done_i while dc_credit_o = 0 → count stays 0 and err_o = 1 until rst_i.
REQ-026 rst_i asserted in HOLD → next cycle l15_val_o = 0 and both credits = 0.
